// File: rtl/bcm_pkg.sv
// Shared types and constants for the binary-counter monitor.
package bcm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } bcm_state_e;

    localparam int ERR_SEQ  = 0;
    localparam int ERR_TICK = 1;

endpackage

// File: rtl/bcm_sat_counter.sv
// W-bit event counter; SATURATE=1 holds at all-ones, SATURATE=0 wraps to zero.
module bcm_sat_counter #(
    parameter int W        = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        // NOTE: next-state defaults to the held value first so no path through the block leaves it unassigned (no latch).
        count_d = count_q;
        if (inc_i && !(SATURATE && (count_q == {W{1'b1}}))) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bin_counter_monitor.sv
// Checks an N-bit free-running counter's q/max_tick pair and reports lock, wraps and errors.
// Define BCM_ERR_CAPTURE_EN to add cap_exp/cap_got, which latch the first error after reset.
module bin_counter_monitor
    import bcm_pkg::*;
#(
    parameter int N        = 8,
    parameter int LOCK_CNT = 4,
    parameter int W        = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] q_in,
    input  logic         max_tick_in,
    output logic         locked,
    output logic         err,
    output logic [1:0]   err_code,
    output logic [W-1:0] err_count,
    output logic [W-1:0] wrap_count
`ifdef BCM_ERR_CAPTURE_EN
    ,
    output logic [N-1:0] cap_exp,
    output logic [N-1:0] cap_got
`endif
);

    localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_CNT - 1);

    bcm_state_e    state_q, state_d;
    logic [N-1:0]  prev_q;
    logic [GW-1:0] good_cnt_q, good_cnt_d;
    logic          locked_q, locked_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          wrap_inc;

    logic [N-1:0]  exp_val;
    logic          seq_bad;
    logic          tick_bad;

    assign exp_val  = prev_q + 1'b1;
    assign seq_bad  = (q_in != exp_val);
    assign tick_bad = (max_tick_in != (q_in == {N{1'b1}}));

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        locked_d   = locked_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        wrap_inc   = 1'b0;

        if (!enable) begin
            state_d    = IDLE;
            locked_d   = 1'b0;
            good_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = ACQ;
                    good_cnt_d = '0;
                end
                // The first sample has no predecessor, so only the tick rule applies here.
                ACQ: begin
                    if (tick_bad) begin
                        err_d                = 1'b1;
                        err_code_d           = '0;
                        err_code_d[ERR_TICK] = 1'b1;
                    end else if (LOCK_CNT == 1) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        state_d    = TRACK;
                        good_cnt_d = GW'(1);
                    end
                end
                TRACK: begin
                    if (seq_bad || tick_bad) begin
                        err_d                = 1'b1;
                        err_code_d[ERR_SEQ]  = seq_bad;
                        err_code_d[ERR_TICK] = tick_bad;
                        state_d              = ACQ;
                        good_cnt_d           = '0;
                    end else if (good_cnt_q == LOCK_LAST) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        good_cnt_d = good_cnt_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (seq_bad || tick_bad) begin
                        err_d                = 1'b1;
                        err_code_d[ERR_SEQ]  = seq_bad;
                        err_code_d[ERR_TICK] = tick_bad;
                        state_d              = ACQ;
                        locked_d             = 1'b0;
                        good_cnt_d           = '0;
                    end else if (max_tick_in) begin
                        wrap_inc = 1'b1;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            if (enable) begin
                prev_q <= q_in;
            end
        end
    end

    bcm_sat_counter #(.W(W), .SATURATE(1'b1)) u_err_count (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (err_d),
        .count_o (err_count)
    );

    bcm_sat_counter #(.W(W), .SATURATE(1'b0)) u_wrap_count (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (wrap_inc),
        .count_o (wrap_count)
    );

    assign locked   = locked_q;
    assign err      = err_q;
    assign err_code = err_code_q;

`ifdef BCM_ERR_CAPTURE_EN
    logic         cap_done_q;
    logic [N-1:0] cap_exp_q;
    logic [N-1:0] cap_got_q;

    // A tick-only error has no meaningful expected count, so both fields record q_in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_done_q <= 1'b0;
            cap_exp_q  <= '0;
            cap_got_q  <= '0;
        end else if (err_d && !cap_done_q) begin
            cap_done_q <= 1'b1;
            cap_exp_q  <= err_code_d[ERR_SEQ] ? exp_val : q_in;
            cap_got_q  <= q_in;
        end
    end

    assign cap_exp = cap_exp_q;
    assign cap_got = cap_got_q;
`endif

endmodule

// File: tb/tb_bin_counter_monitor.sv
// Directed bench for bin_counter_monitor; error pulses are checked by a queue-based scoreboard.
module tb_bin_counter_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        en_req;
    logic [7:0]  q_in;
    logic        max_tick_in;
    logic        locked, err;
    logic [1:0]  err_code;
    logic [15:0] err_count, wrap_count;
    logic        d1_locked, d1_err;
    logic [1:0]  d1_err_code;
    logic [15:0] d1_err_count, d1_wrap_count;
`ifdef BCM_ERR_CAPTURE_EN
    logic [7:0]  cap_exp, cap_got, d1_cap_exp, d1_cap_got;
`endif

    logic [7:0]  cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic [1:0]  code;
        logic [15:0] count;
    } err_exp_t;

    err_exp_t exp_q[$];

    always #5 clk = ~clk;

    bin_counter_monitor #(.N(8), .LOCK_CNT(4), .W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .q_in        (q_in),
        .max_tick_in (max_tick_in),
        .locked      (locked),
        .err         (err),
        .err_code    (err_code),
        .err_count   (err_count),
        .wrap_count  (wrap_count)
`ifdef BCM_ERR_CAPTURE_EN
        ,
        .cap_exp     (cap_exp),
        .cap_got     (cap_got)
`endif
    );

    bin_counter_monitor #(.N(8), .LOCK_CNT(1), .W(16)) dut1 (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .q_in        (q_in),
        .max_tick_in (max_tick_in),
        .locked      (d1_locked),
        .err         (d1_err),
        .err_code    (d1_err_code),
        .err_count   (d1_err_count),
        .wrap_count  (d1_wrap_count)
`ifdef BCM_ERR_CAPTURE_EN
        ,
        .cap_exp     (d1_cap_exp),
        .cap_got     (d1_cap_got)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // One sample: inputs change on the falling edge, outputs are read 1 unit after the rising edge.
    task automatic drive(input logic [7:0] q, input logic t);
        @(negedge clk);
        q_in        = q;
        max_tick_in = t;
        enable      = en_req;
        @(posedge clk);
        #1;
    endtask

    task automatic run_clean(input int n);
        repeat (n) begin
            drive(cnt, cnt == 8'hFF);
            cnt = cnt + 8'd1;
        end
    endtask

    task automatic run_until(input logic [7:0] target);
        for (int i = 0; i < 300 && cnt != target; i++) begin
            drive(cnt, cnt == 8'hFF);
            cnt = cnt + 8'd1;
        end
        check("run_until_reached", {24'd0, cnt}, {24'd0, target});
    endtask

    task automatic expect_err(input logic [1:0] code, input logic [15:0] count);
        err_exp_t e;
        e.code  = code;
        e.count = count;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every err pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        err_exp_t e;
        if (!reset && err === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_err: got pulse code %b count %0d, required no error (t=%0t)",
                         err_code, err_count, $time);
            end else begin
                e = exp_q.pop_front();
                check("err_code", {30'd0, err_code}, {30'd0, e.code});
                check("err_count", {16'd0, err_count}, {16'd0, e.count});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        en_req      = 1'b0;
        q_in        = 8'h00;
        max_tick_in = 1'b0;
        cnt         = 8'h00;

        #12;
        check("rst_locked", {31'd0, locked}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        check("rst_err_count", {16'd0, err_count}, 32'd0);
        check("rst_wrap_count", {16'd0, wrap_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: IDLE edge, ACQ sample, then three TRACK samples to lock
        en_req = 1'b1;
        run_clean(1);
        check("lc1_locked_after_idle", {31'd0, d1_locked}, 32'd0);
        run_clean(1);
        check("lc1_locked_after_acq", {31'd0, d1_locked}, 32'd1);
        check("s1_locked_after_acq", {31'd0, locked}, 32'd0);
        run_clean(2);
        check("s1_locked_before", {31'd0, locked}, 32'd0);
        run_clean(1);
        check("s1_locked", {31'd0, locked}, 32'd1);

        // 2: q=5..604 passes 8'hFF twice while locked
        run_clean(600);
        check("s2_locked", {31'd0, locked}, 32'd1);
        check("s2_wrap_count", {16'd0, wrap_count}, 32'd2);
        check("s2_err_count", {16'd0, err_count}, 32'd0);

        // 3: 8'h37 where 8'h36 is due; the run up to it wraps once more
        run_until(8'h36);
        check("s3_wrap_count", {16'd0, wrap_count}, 32'd3);
        expect_err(2'b01, 16'd1);
        drive(8'h37, 1'b0);
        check("s3_unlocked", {31'd0, locked}, 32'd0);
        cnt = 8'h38;
        run_clean(3);
        check("s3_relock_before", {31'd0, locked}, 32'd0);
        run_clean(1);
        check("s3_relocked", {31'd0, locked}, 32'd1);

        // 4: out-of-sequence 8'hFF without tick, then spurious tick at 8'h10 in ACQ
        expect_err(2'b11, 16'd2);
        drive(8'hFF, 1'b0);
        expect_err(2'b10, 16'd3);
        drive(8'h10, 1'b1);
        cnt = 8'h11;
        run_clean(4);
        check("s4_relocked", {31'd0, locked}, 32'd1);
        check("s4_err_code_held", {30'd0, err_code}, 32'd2);
        check("s4_err_count", {16'd0, err_count}, 32'd3);
        check("s4_wrap_count", {16'd0, wrap_count}, 32'd3);

        // 5: disable for three samples, then reacquire from IDLE
        en_req = 1'b0;
        run_clean(1);
        check("s5_disabled_unlocked", {31'd0, locked}, 32'd0);
        run_clean(2);
        en_req = 1'b1;
        run_clean(4);
        check("s5_relock_before", {31'd0, locked}, 32'd0);
        run_clean(1);
        check("s5_relocked", {31'd0, locked}, 32'd1);
        check("s5_err_count_kept", {16'd0, err_count}, 32'd3);
        check("s5_wrap_count_kept", {16'd0, wrap_count}, 32'd3);
        check("s5_err_code_kept", {30'd0, err_code}, 32'd2);
`ifdef BCM_ERR_CAPTURE_EN
        check("cap_exp", {24'd0, cap_exp}, 32'h36);
        check("cap_got", {24'd0, cap_got}, 32'h37);
`endif

        // 6: asynchronous reset while in TRACK
        en_req = 1'b0;
        run_clean(1);
        en_req = 1'b1;
        run_clean(3);
        @(negedge clk);
        reset  = 1'b1;
        en_req = 1'b0;
        enable = 1'b0;
        #1;
        check("s6_locked", {31'd0, locked}, 32'd0);
        check("s6_err_code", {30'd0, err_code}, 32'd0);
        check("s6_err_count", {16'd0, err_count}, 32'd0);
        check("s6_wrap_count", {16'd0, wrap_count}, 32'd0);
`ifdef BCM_ERR_CAPTURE_EN
        check("s6_cap_exp", {24'd0, cap_exp}, 32'd0);
        check("s6_cap_got", {24'd0, cap_got}, 32'd0);
`endif
        @(negedge clk);
        reset  = 1'b0;
        en_req = 1'b1;
        run_clean(4);
        check("s6_reacq_before", {31'd0, locked}, 32'd0);
        run_clean(1);
        check("s6_reacquired", {31'd0, locked}, 32'd1);

        run_clean(2);
        check("err_queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
